tmr_scrub_scheduler: RTL

//  Scheduler that sequences refresh (scrub) of N_BANKS triplicated register banks.

---
 rtl/tmr_scrub_pkg.sv | 20 ++
 rtl/tmr_rr_arbiter.sv | 39 +++
 rtl/tmr_scrub_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tmr_scrub_pkg.sv
// Shared types for the TMR scrub scheduler: FSM state enum,
// reset constants and the bank index type for the default bank count.
package tmr_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_BANKS_DEF = 4;
    localparam int BANK_IDX_W  = $clog2(N_BANKS_DEF);

    typedef logic [BANK_IDX_W-1:0] bank_idx_t;

    localparam state_t STATE_RST = IDLE;
    localparam logic   REQ_RST   = 1'b0;
    localparam logic   DUE_RST   = 1'b0;

endpackage

// File: rtl/tmr_rr_arbiter.sv
// Combinational round-robin pick: first set bit of i_mask at or
// after i_ptr, wrapping. Ports: i_mask, i_ptr -> o_grant, o_valid.
module tmr_rr_arbiter
    import tmr_scrub_pkg::*;
#(
    parameter int N = N_BANKS_DEF
) (
    input  logic [N-1:0]         i_mask,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [$clog2(N)-1:0] o_grant,
    output logic                 o_valid
);

    localparam int IW = $clog2(N);

    int             w_pos;
    logic [IW-1:0]  w_idx;

    // Walk from the far end back to i_ptr so the last hit,
    // i.e. the nearest bank at or after the pointer, wins.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_idx = IW'(w_pos);
            if (i_mask[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmr_scrub_scheduler.sv
// Scrub scheduler for N_BANKS triplicated banks: errored banks first
// (round-robin), else a periodic background sweep; req/ack handshake.
// Ports: clk, rstn, enable_i, period_i, mismatch_i, refresh_ack_i in;
// refresh_req_o, refresh_sel_o, pending_o, err_count_o, busy_o out.
// Macro TMR_SCRUB_TIMEOUT_EN adds an ack timeout and timeout_o.
module tmr_scrub_scheduler
    import tmr_scrub_pkg::*;
#(
    parameter int N_BANKS  = N_BANKS_DEF,
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       enable_i,
    input  logic [PERIOD_W-1:0]        period_i,
    input  logic [N_BANKS-1:0]         mismatch_i,
    output logic                       refresh_req_o,
    output logic [$clog2(N_BANKS)-1:0] refresh_sel_o,
    input  logic                       refresh_ack_i,
    output logic [N_BANKS-1:0]         pending_o,
    output logic [CNT_W-1:0]           err_count_o,
`ifdef TMR_SCRUB_TIMEOUT_EN
    output logic                       timeout_o,
`endif
    output logic                       busy_o
);

    localparam int IDX_W = $clog2(N_BANKS);

    state_t              r_state;
    logic                r_req;
    logic                r_busy;
    logic [IDX_W-1:0]    r_sel;
    logic                r_sweep;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_sweep_ptr;
    logic                r_due;
    logic                r_loaded;
    logic [PERIOD_W-1:0] r_tmr;
    logic [N_BANKS-1:0]  r_pending;
    logic [CNT_W-1:0]    r_err;

    logic [IDX_W-1:0]    w_grant;
    logic                w_gvalid;
    logic [IDX_W-1:0]    w_sel_inc;
    logic [N_BANKS-1:0]  w_clr;
    logic                w_tick;
    logic                w_reload;
    logic                w_due_set;
    logic                w_abort;

    tmr_rr_arbiter #(
        .N (N_BANKS)
    ) u_arb (
        .i_mask  (r_pending),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_valid (w_gvalid)
    );

`ifdef TMR_SCRUB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    // r_timeout is high exactly in DONE of an aborted request.
    assign w_abort   = r_timeout;
    assign timeout_o = r_timeout;
`else
    // TIMEOUT has no effect without the timeout build.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
    assign w_abort = 1'b0;
`endif

    // Timer only advances while enabled with a nonzero period.
    assign w_tick    = enable_i && (period_i != '0);
    assign w_reload  = !r_loaded || (r_tmr == '0);
    assign w_due_set = w_tick && r_loaded && (r_tmr == '0);

    assign w_sel_inc = (r_sel == IDX_W'(N_BANKS - 1))
                     ? '0 : r_sel + IDX_W'(1);

    // Sweep refreshes and aborted requests leave the mask alone.
    always_comb begin
        w_clr = '0;
        if (r_state == DONE && !r_sweep && !w_abort) begin
            w_clr[r_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= STATE_RST;
            r_req       <= REQ_RST;
            r_busy      <= 1'b0;
            r_sel       <= '0;
            r_sweep     <= 1'b0;
            r_rr_ptr    <= '0;
            r_sweep_ptr <= '0;
            r_due       <= DUE_RST;
            r_loaded    <= 1'b0;
            r_tmr       <= '0;
            r_pending   <= '0;
            r_err       <= '0;
`ifdef TMR_SCRUB_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            // A new mismatch beats a same-cycle clear.
            r_pending <= (r_pending & ~w_clr) | mismatch_i;

            if (w_tick) begin
                r_loaded <= 1'b1;
                r_tmr    <= w_reload ? period_i - PERIOD_W'(1)
                                     : r_tmr - PERIOD_W'(1);
            end

            if (r_state == DONE && r_sweep) begin
                r_due <= 1'b0;
            end
            if (w_due_set) begin
                r_due <= 1'b1;
            end

            unique case (r_state)
                IDLE: begin
`ifdef TMR_SCRUB_TIMEOUT_EN
                    r_to_cnt  <= '0;
                    r_timeout <= 1'b0;
`endif
                    if (enable_i && (w_gvalid || r_due)) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_sweep <= !w_gvalid;
                        r_sel   <= w_gvalid ? w_grant : r_sweep_ptr;
                    end
                end
                REQ: begin
                    if (refresh_ack_i) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
`ifdef TMR_SCRUB_TIMEOUT_EN
                    end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_state   <= DONE;
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`ifdef TMR_SCRUB_TIMEOUT_EN
                    r_timeout <= 1'b0;
`endif
                    if (r_sweep) begin
                        r_sweep_ptr <= w_sel_inc;
                    end else begin
                        r_rr_ptr <= w_sel_inc;
                        if (r_err != '1) begin
                            r_err <= r_err + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign refresh_req_o = r_req;
    assign refresh_sel_o = r_sel;
    assign pending_o     = r_pending;
    assign err_count_o   = r_err;
    assign busy_o        = r_busy;

endmodule
